// File: rtl/dp_ram16k_fifo_ctrl.sv
// dp_ram16k_fifo_ctrl: single-clock 32-bit stream FIFO controller that uses one
// DP_RAM16K (512x32, 1-cycle read latency) as storage, plus a one-word output stage
// formed by the RAM output register and m_valid.
// Optional almost-full/almost-empty flags are built when the macro
// DP_FIFO_ALMOST_EN is defined; without it the afull/aempty ports do not exist.
module dp_ram16k_fifo_ctrl #(
  parameter int ADDR_W    = 9,
  parameter int AFULL_TH  = 480,
  parameter int AEMPTY_TH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [31:0]       m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W:0]   level,
  output logic              ram_wen,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [31:0]       ram_d_in,
  output logic [31:0]       ram_wenb,
  input  logic [31:0]       ram_d_out
`ifdef DP_FIFO_ALMOST_EN
  ,
  output logic              afull,
  output logic              aempty
`endif
);

  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              m_valid_nxt;
  logic              full;
  logic              push;
  logic              pop_ram;

  // Handshakes and RAM strobes; ready stays low during the cycle a pop frees a slot.
  assign full      = (cnt == DEPTH);
  assign s_ready   = ~full;
  assign push      = s_valid & s_ready;
  // Refill the output stage whenever it is empty or being drained this cycle.
  assign pop_ram   = (cnt != '0) & (~m_valid | m_ready);

  assign ram_wen   = ~push;
  assign ram_ren   = ~pop_ram;
  assign ram_waddr = wptr;
  assign ram_raddr = rptr;
  assign ram_d_in  = s_data;
  assign ram_wenb  = '1;

  // RAM output register only changes on pop_ram edges, so it holds under back-pressure.
  assign m_data    = ram_d_out;
  assign level     = cnt + {{ADDR_W{1'b0}}, m_valid};

  // Next-state occupancy of the RAM and of the output stage.
  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop_ram})
      2'b10:   cnt_nxt = cnt + CNT_ONE;
      2'b01:   cnt_nxt = cnt - CNT_ONE;
      default: cnt_nxt = cnt;
    endcase
    m_valid_nxt = m_valid;
    if (pop_ram)
      m_valid_nxt = 1'b1;
    else if (m_ready)
      m_valid_nxt = 1'b0;
  end

  // Pointer, count and output-valid registers; reset discards all in-flight words.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      m_valid <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + PTR_ONE;
      if (pop_ram)
        rptr <= rptr + PTR_ONE;
      cnt     <= cnt_nxt;
      m_valid <= m_valid_nxt;
    end
  end

`ifdef DP_FIFO_ALMOST_EN
  localparam logic [ADDR_W:0] AFULL_LV  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_LV = (ADDR_W+1)'(AEMPTY_TH);

  logic [ADDR_W:0] level_nxt;

  assign level_nxt = cnt_nxt + {{ADDR_W{1'b0}}, m_valid_nxt};

  // Flags registered from next-state level so they move in the same cycle as level.
  always_ff @(posedge clk) begin
    if (reset) begin
      afull  <= 1'b0;
      aempty <= 1'b1;
    end else begin
      afull  <= (level_nxt >= AFULL_LV);
      aempty <= (level_nxt <= AEMPTY_LV);
    end
  end
`endif

endmodule
